// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the split L1 caches and the unified L2 request port.
// One transaction in flight; every output comes straight from a register.
module l2_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  i_address,
  input  logic         i_read,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic [15:0]  d_address,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic [15:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t              state;
  logic                last_grant_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                op_q;
  logic [LINE_W-1:0]   rdata_q;

  logic req_i_c;
  logic req_d_c;
  logic grant_d_c;

  // D wins when it is the only requester, or on a tie when I was served last.
  always_comb begin
    req_i_c   = i_read;
    req_d_c   = d_read | d_write;
    grant_d_c = req_d_c & (~req_i_c | ~last_grant_d);
  end

  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_rdata    = rdata_q;
  assign d_rdata    = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
      rdata_q      <= '0;
      l2_read      <= 1'b0;
      l2_write     <= 1'b0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i_c | req_d_c) begin
            last_grant_d <= grant_d_c;
            if (grant_d_c) begin
              addr_q   <= d_address;
              wdata_q  <= d_wdata;
              op_q     <= d_write ? OP_WRITE : OP_READ;
              l2_read  <= ~d_write;
              l2_write <= d_write;
              state    <= SERVE_D;
            end else begin
              addr_q   <= i_address;
              op_q     <= OP_READ;
              l2_read  <= 1'b1;
              l2_write <= 1'b0;
              state    <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            rdata_q  <= l2_rdata;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            if (state == SERVE_I) begin
              i_resp <= 1'b1;
              state  <= RESP_I;
            end else begin
              d_resp <= 1'b1;
              state  <= RESP_D;
            end
          end
        end
        RESP_I, RESP_D: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
          i_resp   <= 1'b0;
          d_resp   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  i_address;
  logic         i_read;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic [15:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic [15:0]  l2_address;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  int errors = 0;
  int checks = 0;

  l2_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: which requester owns the L2 port and what it asked for.
  // m_phase: 0 = no transaction, 1 = L2 request outstanding, 2 = answer being returned.
  int           m_phase;
  bit           m_owner_d;
  bit           m_last_d;
  bit           m_is_write;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  logic [127:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_owner_d = 0; m_last_d = 1; m_is_write = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_phase == 0) begin
      if (i_read || d_read || d_write) begin
        m_owner_d  = (d_read || d_write) && (!i_read || !m_last_d);
        m_last_d   = m_owner_d;
        m_addr     = m_owner_d ? d_address : i_address;
        m_is_write = m_owner_d && d_write;
        m_wdata    = d_wdata;
        m_phase    = 1;
      end
    end else if (m_phase == 1) begin
      if (l2_resp) begin
        m_rdata = l2_rdata;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {l2_read, l2_write, i_resp, d_resp, l2_address}, '0);
    end else begin
      chk("m_l2_read",  128'(l2_read),  128'(m_phase == 1 && !m_is_write));
      chk("m_l2_write", 128'(l2_write), 128'(m_phase == 1 && m_is_write));
      chk("m_i_resp",   128'(i_resp),   128'(m_phase == 2 && !m_owner_d));
      chk("m_d_resp",   128'(d_resp),   128'(m_phase == 2 && m_owner_d));
      if (m_phase == 1) chk("m_l2_address", 128'(l2_address), 128'(m_addr));
      if (m_phase == 1 && m_is_write) chk("m_l2_wdata", l2_wdata, m_wdata);
      if (m_phase == 2 && !m_owner_d) chk("m_i_rdata", i_rdata, m_rdata);
      if (m_phase == 2 && m_owner_d && !m_is_write) chk("m_d_rdata", d_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] pat_a5;
  logic [127:0] pat_wb;
  int resp_count;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_wb = 128'h0123456789ABCDEF0123456789ABCDEF;
    rst_n = 1'b0;
    i_address = '0; i_read = 0; d_address = '0; d_read = 0; d_write = 0;
    d_wdata = '0; l2_rdata = '0; l2_resp = 0;

    // Outputs stay zero under reset while inputs churn.
    repeat (3) begin
      tick();
      chk("reset_l2_req", {l2_read, l2_write, i_resp, d_resp}, '0);
      chk("reset_l2_address", 128'(l2_address), '0);
      i_read = 1'($urandom); d_write = 1'($urandom); l2_resp = 1'($urandom);
      i_address = 16'($urandom); d_address = 16'($urandom); l2_rdata = rnd128();
    end
    tick();
    rst_n = 1'b1; i_read = 1; i_address = 16'h1230; d_read = 0; d_write = 0; l2_resp = 0;

    // Single I read, L2 answers after five request cycles.
    tick();
    chk("rel_l2_read", 128'(l2_read), 128'(1));
    chk("rel_l2_address", 128'(l2_address), 128'(16'h1230));
    chk("rel_l2_write", 128'(l2_write), '0);
    repeat (4) begin tick(); chk("i_hold_l2_read", 128'(l2_read), 128'(1)); end
    l2_resp = 1; l2_rdata = pat_a5;
    tick();
    l2_resp = 0; l2_rdata = '0;
    chk("i_resp_pulse", 128'(i_resp), 128'(1));
    chk("i_rdata", i_rdata, pat_a5);
    chk("i_no_d_resp", 128'(d_resp), '0);
    i_read = 0;
    tick();
    chk("i_resp_one_cycle", 128'(i_resp), '0);

    // D write-back.
    d_write = 1; d_address = 16'hFE00; d_wdata = pat_wb;
    tick();
    chk("wb_l2_write", 128'(l2_write), 128'(1));
    chk("wb_l2_read", 128'(l2_read), '0);
    d_address = 16'h0000; d_wdata = '0;
    repeat (3) begin
      tick();
      chk("wb_l2_address", 128'(l2_address), 128'(16'hFE00));
      chk("wb_l2_wdata", l2_wdata, pat_wb);
    end
    l2_resp = 1;
    tick();
    l2_resp = 0;
    chk("wb_d_resp", 128'(d_resp), 128'(1));
    chk("wb_no_i_resp", 128'(i_resp), '0);
    d_write = 0;
    tick();
    chk("wb_d_resp_one_cycle", 128'(d_resp), '0);

    // Tie with last grant = D: I first, then D three cycles after I's L2 answer.
    i_read = 1; i_address = 16'h1111; d_read = 1; d_address = 16'h2222;
    tick();
    chk("tie1_i_first", 128'(l2_address), 128'(16'h1111));
    i_address = 16'hBEEF;
    tick();
    chk("churn_addr_held", 128'(l2_address), 128'(16'h1111));
    l2_resp = 1;
    tick();
    l2_resp = 0;
    chk("tie1_i_resp", 128'(i_resp), 128'(1));
    i_read = 0;
    tick();
    chk("tie1_idle_gap", 128'(l2_read), '0);
    tick();
    chk("tie1_d_next", 128'(l2_address), 128'(16'h2222));
    chk("tie1_d_read", 128'(l2_read), 128'(1));
    l2_resp = 1;
    tick();
    l2_resp = 0; d_read = 0;
    tick();

    // I alone, then a tie with last grant = I: D wins.
    i_read = 1; i_address = 16'h3333;
    tick();
    l2_resp = 1;
    tick();
    l2_resp = 0; i_read = 0;
    tick();
    i_read = 1; i_address = 16'h5555; d_read = 1; d_address = 16'h6666;
    tick();
    chk("tie2_d_first", 128'(l2_address), 128'(16'h6666));
    l2_resp = 1;
    tick();
    l2_resp = 0;
    chk("tie2_d_resp", 128'(d_resp), 128'(1));
    chk("tie2_no_i_resp", 128'(i_resp), '0);
    d_read = 0;
    tick();
    tick();
    chk("tie2_i_second", 128'(l2_address), 128'(16'h5555));
    l2_resp = 1;
    tick();
    l2_resp = 0; i_read = 0;
    tick();

    // Reset during SERVE_D with the L2 answer pending.
    d_write = 1; d_address = 16'h4444; d_wdata = rnd128();
    tick();
    chk("mid_l2_write", 128'(l2_write), 128'(1));
    l2_resp = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_l2_write", 128'(l2_write), '0);
    chk("mid_rst_d_resp", 128'(d_resp), '0);
    d_write = 0; l2_resp = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {l2_read, l2_write, i_resp, d_resp}, '0);
    i_read = 1; i_address = 16'h7777; d_read = 1; d_address = 16'h8888;
    tick();
    chk("post_rst_i_wins", 128'(l2_address), 128'(16'h7777));
    l2_resp = 1;
    tick();
    l2_resp = 0; i_read = 0;
    tick();
    tick();
    chk("post_rst_d_next", 128'(l2_address), 128'(16'h8888));
    l2_resp = 1;
    tick();
    l2_resp = 0; d_read = 0;
    tick();

    // Randomized traffic; the model checks every cycle.
    resp_count = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (i_resp || d_resp) resp_count++;
      if (i_read && i_resp) i_read = 0;
      else if (!i_read && ($urandom % 4 == 0)) begin
        i_read = 1; i_address = 16'($urandom);
      end else if ($urandom % 8 == 0) i_address = 16'($urandom);

      if ((d_read || d_write) && d_resp) begin
        d_read = 0; d_write = 0;
      end else if (!(d_read || d_write) && ($urandom % 4 == 0)) begin
        case ($urandom % 3)
          0:       begin d_read = 1; d_write = 0; end
          1:       begin d_read = 0; d_write = 1; end
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_address = 16'($urandom); d_wdata = rnd128();
      end else if ($urandom % 8 == 0) begin
        d_address = 16'($urandom); d_wdata = rnd128();
      end

      l2_rdata = rnd128();
      if (l2_read || l2_write) l2_resp = ($urandom % 4 == 0);
      else l2_resp = ($urandom % 8 == 0);
    end
    chk("random_progress", 128'(resp_count > 200), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
